// File: rtl/ticket_server_pkg.sv
// ticket_server_pkg
//   Shared types and constants for the ticket server and its per-requester
//   slots: the slot state encoding and the reset values of the ticket,
//   next-ticket and now-serving counters.
package ticket_server_pkg;

  // Slot life cycle: waiting for a ticket, holding a ticket, in the
  // critical section.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CRIT = 2'd2
  } tkstate;

  // Raw encodings of the slot state register (same values as tkstate).
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_CRIT = 2'd2;

  // Reset values of the counters.
  localparam int unsigned TICKET_RST  = 0;
  localparam int unsigned NEXT_TK_RST = 0;
  localparam int unsigned SERVING_RST = 0;

endpackage

// File: rtl/ticket_server_if.sv
// ticket_server_if
//   Bundles the requester-facing signals of the ticket server.
//   master: the requester side (drives select/req/rel).
//   slave : the ticket server (drives grant/next_tk/serving/violation).
//   select    : nondeterministic choice of requester allowed to take a ticket
//   req, rel  : per-requester ticket request and critical-section release
//   grant     : per-requester critical-section indication
//   next_tk   : next ticket to be issued
//   serving   : ticket currently being served
//   violation : sticky error flag from the optional checker
interface ticket_server_if #(
  parameter int TKMSB  = 3,
  parameter int HIPROC = 1,
  parameter int SELMSB = 1
);
  logic [SELMSB:0] select;
  logic [HIPROC:0] req;
  logic [HIPROC:0] rel;
  logic [HIPROC:0] grant;
  logic [TKMSB:0]  next_tk;
  logic [TKMSB:0]  serving;
  logic            violation;

  modport master (
    output select, req, rel,
    input  grant, next_tk, serving, violation
  );

  modport slave (
    input  select, req, rel,
    output grant, next_tk, serving, violation
  );
endinterface

// File: rtl/ticket_server_slot.sv
// ticket_slot
//   Per-requester state machine of the ticket server.
//   clock, reset : clock and synchronous active-high reset
//   issue        : this slot is being handed tk_in on this edge (IDLE only)
//   tk_in        : ticket being issued
//   serving      : current now-serving value (pre-edge)
//   rel          : requester leaves the critical section (CRIT only)
//   state        : IDLE / WAIT / CRIT
//   ticket       : ticket held, 0 while IDLE
//   rel_ack      : release accepted this cycle; advances serving
module ticket_slot
  import ticket_server_pkg::*;
#(
  parameter int TKMSB = 3
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           issue,
  input  logic [TKMSB:0] tk_in,
  input  logic [TKMSB:0] serving,
  input  logic           rel,
  output tkstate         state,
  output logic [TKMSB:0] ticket,
  output logic           rel_ack
);

  localparam logic [TKMSB:0] TK_RST = (TKMSB+1)'(TICKET_RST);

  logic [1:0] state_q;

  // WAIT->CRIT compares against the pre-edge serving, so a release and the
  // following grant always land on separate edges.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ticket  <= TK_RST;
    end else begin
      case (state_q)
        ST_IDLE: if (issue) begin
          state_q <= ST_WAIT;
          ticket  <= tk_in;
        end
        ST_WAIT: if (ticket == serving) state_q <= ST_CRIT;
        ST_CRIT: if (rel) begin
          state_q <= ST_IDLE;
          ticket  <= TK_RST;
        end
        default: begin
          state_q <= ST_IDLE;
          ticket  <= TK_RST;
        end
      endcase
    end
  end

  assign state   = tkstate'(state_q);
  assign rel_ack = (state_q == ST_CRIT) && rel;

endmodule

// File: rtl/ticket_server.sv
// ticket_server
//   Central ticket dispenser and now-serving counter (serving end of the
//   bakery protocol) for HIPROC+1 requesters. One ticket is issued per edge
//   at most, to the requester picked by select, so tickets never tie.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : select/req/rel in, grant/next_tk/serving/violation out
//   Optional macro TICKET_SERVER_CHECK_EN: enables the sticky violation
//   checker (more than one grant, or a WAIT ticket outside
//   [serving, next_tk)); otherwise violation is tied low.
module ticket_server
  import ticket_server_pkg::*;
#(
  parameter int TKMSB  = 3,
  parameter int HIPROC = 1,
  parameter int SELMSB = 1
) (
  input  logic              clock,
  input  logic              reset,
  ticket_server_if.slave    bus
);

  localparam logic [SELMSB:0] HI_SEL  = (SELMSB+1)'(HIPROC);
  localparam logic [TKMSB:0]  NXT_RST = (TKMSB+1)'(NEXT_TK_RST);
  localparam logic [TKMSB:0]  SRV_RST = (TKMSB+1)'(SERVING_RST);

  logic [SELMSB:0] sel;
  logic [TKMSB:0]  next_tk_q;
  logic [TKMSB:0]  serving_q;
  logic [HIPROC:0] issue;
  logic [HIPROC:0] rel_ack;
  logic [HIPROC:0] grant;
  tkstate          st  [HIPROC+1];
  logic [TKMSB:0]  tks [HIPROC+1];

  // Out-of-range select values fall back to requester 0.
  assign sel = (bus.select > HI_SEL) ? '0 : bus.select;

  // Only the selected, idle requester can take a ticket this edge.
  for (genvar i = 0; i <= HIPROC; i++) begin : g_slot
    assign issue[i] = bus.req[i] && (sel == (SELMSB+1)'(i)) && (st[i] == IDLE);
    assign grant[i] = (st[i] == CRIT);

    ticket_slot #(.TKMSB(TKMSB)) u_slot (
      .clock   (clock),
      .reset   (reset),
      .issue   (issue[i]),
      .tk_in   (next_tk_q),
      .serving (serving_q),
      .rel     (bus.rel[i]),
      .state   (st[i]),
      .ticket  (tks[i]),
      .rel_ack (rel_ack[i])
    );
  end

  // Issue and release may coincide; both counters then advance together.
  always_ff @(posedge clock) begin
    if (reset) begin
      next_tk_q <= NXT_RST;
      serving_q <= SRV_RST;
    end else begin
      if (|issue)   next_tk_q <= next_tk_q + 1'b1;
      if (|rel_ack) serving_q <= serving_q + 1'b1;
    end
  end

  assign bus.grant   = grant;
  assign bus.next_tk = next_tk_q;
  assign bus.serving = serving_q;

`ifdef TICKET_SERVER_CHECK_EN
  logic [TKMSB:0] span;
  logic [TKMSB:0] offs [HIPROC+1];
  logic           multi_grant;
  logic           bad_window;
  logic           violation_q;

  // Offsets are taken modulo the counter width so the window check
  // survives wrap-around.
  assign span = next_tk_q - serving_q;
  for (genvar i = 0; i <= HIPROC; i++) begin : g_off
    assign offs[i] = tks[i] - serving_q;
  end

  always_comb begin
    multi_grant = ($countones(grant) > 1);
    bad_window  = 1'b0;
    for (int k = 0; k <= HIPROC; k++) begin
      if ((st[k] == WAIT) && (offs[k] >= span)) bad_window = 1'b1;
    end
  end

  // Sticky until reset.
  always_ff @(posedge clock) begin
    if (reset)                           violation_q <= 1'b0;
    else if (multi_grant || bad_window)  violation_q <= 1'b1;
  end

  assign bus.violation = violation_q;
`else
  assign bus.violation = 1'b0;
`endif

endmodule

// File: tb/tb_ticket_server.sv
// tb_ticket_server
//   Self-checking bench for ticket_server (TKMSB=1, HIPROC=1, SELMSB=1 so
//   the 2-bit counters wrap quickly). A table of directed vectors covers
//   reset, issue/grant/release, select clamping, ignored inputs and a
//   simultaneous issue+release; hand-written sequences cover counter wrap
//   and reset during CRIT; a long random run is compared against a small
//   behavioural model. Works with or without TICKET_SERVER_CHECK_EN
//   (violation must stay 0 either way).
module tb_ticket_server;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  ticket_server_if #(.TKMSB(1), .HIPROC(1), .SELMSB(1)) bus ();

  ticket_server #(.TKMSB(1), .HIPROC(1), .SELMSB(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       rst;
    logic [1:0] sel;
    logic [1:0] req;
    logic [1:0] rel;
    logic [1:0] grant;
    logic [1:0] next;
    logic [1:0] serv;
  } vec_t;

  localparam int NV = 22;
  vec_t  vecs  [NV];
  string vnames[NV];

  // Model state for the random phase.
  int       mstate [2];
  logic [1:0] mtk  [2];
  logic [1:0] mnext;
  logic [1:0] mserv;

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] s,
                               input logic [1:0] q, input logic [1:0] l);
    reset      = r;
    bus.select = s;
    bus.req    = q;
    bus.rel    = l;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic setVec(input int idx, input string name, input vec_t v);
    vecs[idx]   = v;
    vnames[idx] = name;
  endtask

  // Behavioural model of one edge, using pre-edge values throughout.
  task automatic modelEdge(input logic [1:0] s, input logic [1:0] q,
                           input logic [1:0] l);
    int         who;
    int         nstate [2];
    logic [1:0] ntk    [2];
    logic       did_issue;
    logic       did_rel;
    who       = (s > 2'd1) ? 0 : int'(s);
    did_issue = 1'b0;
    did_rel   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      nstate[i] = mstate[i];
      ntk[i]    = mtk[i];
      if (mstate[i] == 0 && q[i] && who == i) begin
        nstate[i] = 1;
        ntk[i]    = mnext;
        did_issue = 1'b1;
      end else if (mstate[i] == 1 && mtk[i] == mserv) begin
        nstate[i] = 2;
      end else if (mstate[i] == 2 && l[i]) begin
        nstate[i] = 0;
        ntk[i]    = 2'd0;
        did_rel   = 1'b1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      mstate[i] = nstate[i];
      mtk[i]    = ntk[i];
    end
    if (did_issue) mnext = mnext + 2'd1;
    if (did_rel)   mserv = mserv + 2'd1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    applyStimulus(1'b1, 2'd0, 2'b00, 2'b00);

    //            rst  sel   req    rel    grant  next  serv
    setVec(0,  "reset",          '{1'b1, 2'd0, 2'b00, 2'b00, 2'b00, 2'd0, 2'd0});
    setVec(1,  "t1_issue",       '{1'b0, 2'd0, 2'b01, 2'b00, 2'b00, 2'd1, 2'd0});
    setVec(2,  "t1_grant",       '{1'b0, 2'd0, 2'b00, 2'b00, 2'b01, 2'd1, 2'd0});
    setVec(3,  "t1_release",     '{1'b0, 2'd0, 2'b00, 2'b01, 2'b00, 2'd1, 2'd1});
    setVec(4,  "t2_reset",       '{1'b1, 2'd0, 2'b00, 2'b00, 2'b00, 2'd0, 2'd0});
    setVec(5,  "t2_issue1",      '{1'b0, 2'd1, 2'b11, 2'b00, 2'b00, 2'd1, 2'd0});
    setVec(6,  "t2_issue0_g1",   '{1'b0, 2'd0, 2'b11, 2'b00, 2'b10, 2'd2, 2'd0});
    setVec(7,  "t2_hold1",       '{1'b0, 2'd0, 2'b00, 2'b00, 2'b10, 2'd2, 2'd0});
    setVec(8,  "t2_rel1",        '{1'b0, 2'd0, 2'b00, 2'b10, 2'b00, 2'd2, 2'd1});
    setVec(9,  "t2_grant0",      '{1'b0, 2'd0, 2'b00, 2'b00, 2'b01, 2'd2, 2'd1});
    setVec(10, "t2_rel0",        '{1'b0, 2'd0, 2'b00, 2'b01, 2'b00, 2'd2, 2'd2});
    setVec(11, "t3_reset",       '{1'b1, 2'd0, 2'b00, 2'b00, 2'b00, 2'd0, 2'd0});
    setVec(12, "t3_req1_ign",    '{1'b0, 2'd3, 2'b10, 2'b00, 2'b00, 2'd0, 2'd0});
    setVec(13, "t3_clamp_issue", '{1'b0, 2'd3, 2'b01, 2'b00, 2'b00, 2'd1, 2'd0});
    setVec(14, "t3_req_busy",    '{1'b0, 2'd3, 2'b01, 2'b00, 2'b01, 2'd1, 2'd0});
    setVec(15, "t3_release",     '{1'b0, 2'd0, 2'b00, 2'b01, 2'b00, 2'd1, 2'd1});
    setVec(16, "t3_rel_ign",     '{1'b0, 2'd0, 2'b00, 2'b11, 2'b00, 2'd1, 2'd1});
    setVec(17, "sim_issue0",     '{1'b0, 2'd0, 2'b01, 2'b00, 2'b00, 2'd2, 2'd1});
    setVec(18, "sim_grant0",     '{1'b0, 2'd0, 2'b00, 2'b00, 2'b01, 2'd2, 2'd1});
    setVec(19, "sim_issue_rel",  '{1'b0, 2'd1, 2'b10, 2'b01, 2'b00, 2'd3, 2'd2});
    setVec(20, "sim_grant1",     '{1'b0, 2'd0, 2'b00, 2'b00, 2'b10, 2'd3, 2'd2});
    setVec(21, "sim_rel1",       '{1'b0, 2'd0, 2'b00, 2'b10, 2'b00, 2'd3, 2'd3});

    #2;
    for (int v = 0; v < NV; v++) begin
      applyStimulus(vecs[v].rst, vecs[v].sel, vecs[v].req, vecs[v].rel);
      step();
      checkOutput({vnames[v], "_grant"}, 32'(bus.grant),   32'(vecs[v].grant));
      checkOutput({vnames[v], "_next"},  32'(bus.next_tk), 32'(vecs[v].next));
      checkOutput({vnames[v], "_serv"},  32'(bus.serving), 32'(vecs[v].serv));
      checkOutput({vnames[v], "_viol"},  32'(bus.violation), 32'd0);
    end

    // Six rounds on alternating requesters: counters wrap 3->0.
    applyStimulus(1'b1, 2'd0, 2'b00, 2'b00);
    step();
    for (int i = 0; i < 6; i++) begin
      int r;
      r = i % 2;
      applyStimulus(1'b0, 2'(r), 2'(1 << r), 2'b00);
      step();
      checkOutput("wrap_next",      32'(bus.next_tk), 32'((i + 1) % 4));
      checkOutput("wrap_nogrant",   32'(bus.grant),   32'd0);
      applyStimulus(1'b0, 2'd0, 2'b00, 2'b00);
      step();
      checkOutput("wrap_grant",     32'(bus.grant),   32'(1 << r));
      checkOutput("wrap_serv_hold", 32'(bus.serving), 32'(i % 4));
      applyStimulus(1'b0, 2'd0, 2'b00, 2'(1 << r));
      step();
      checkOutput("wrap_serv",      32'(bus.serving), 32'((i + 1) % 4));
      checkOutput("wrap_released",  32'(bus.grant),   32'd0);
    end

    // Reset while slot0 is in CRIT and slot1 in WAIT.
    applyStimulus(1'b1, 2'd0, 2'b00, 2'b00);
    step();
    applyStimulus(1'b0, 2'd0, 2'b01, 2'b00);
    step();
    applyStimulus(1'b0, 2'd1, 2'b10, 2'b00);
    step();
    checkOutput("rst_pre_grant", 32'(bus.grant),   32'b01);
    checkOutput("rst_pre_next",  32'(bus.next_tk), 32'd2);
    applyStimulus(1'b1, 2'd1, 2'b10, 2'b00);
    step();
    checkOutput("rst_grant", 32'(bus.grant),   32'd0);
    checkOutput("rst_next",  32'(bus.next_tk), 32'd0);
    checkOutput("rst_serv",  32'(bus.serving), 32'd0);
    applyStimulus(1'b0, 2'd1, 2'b10, 2'b00);
    step();
    checkOutput("rst_new_next", 32'(bus.next_tk), 32'd1);
    applyStimulus(1'b0, 2'd0, 2'b00, 2'b00);
    step();
    checkOutput("rst_new_grant", 32'(bus.grant), 32'b10);

    // Random run against the model.
    applyStimulus(1'b1, 2'd0, 2'b00, 2'b00);
    step();
    for (int i = 0; i < 2; i++) begin
      mstate[i] = 0;
      mtk[i]    = 2'd0;
    end
    mnext = 2'd0;
    mserv = 2'd0;
    for (int c = 0; c < 10000; c++) begin
      logic [1:0] s, q, l;
      logic [1:0] mgrant;
      s = 2'($urandom_range(0, 3));
      q = 2'($urandom_range(0, 3));
      l = 2'($urandom_range(0, 3));
      applyStimulus(1'b0, s, q, l);
      step();
      modelEdge(s, q, l);
      mgrant = {mstate[1] == 2, mstate[0] == 2};
      checkOutput("rnd_grant", 32'(bus.grant),   32'(mgrant));
      checkOutput("rnd_next",  32'(bus.next_tk), 32'(mnext));
      checkOutput("rnd_serv",  32'(bus.serving), 32'(mserv));
      checkOutput("rnd_onehot", 32'($countones(bus.grant) <= 1), 32'd1);
      checkOutput("rnd_viol",  32'(bus.violation), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
